// File: rtl/ram16_frame_ctrl.sv
// rtl/ram16_frame_ctrl.sv - single-frame RAM16 sample buffer sequencer (optional auto-clear: RAM16_CTRL_AUTOCLR_EN)
`timescale 1ns/1ps
module ram16_frame_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [15:0]           S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [15:0]           M_DATA,
    output logic                  M_LAST,
    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic                  RAM_CLR,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    output logic [15:0]           RAM_DI,
    input  logic [15:0]           RAM_DO,
    output logic                  BUSY,
    output logic [FCNT_WIDTH-1:0] FRAME_CNT
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FILL     = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_CAP   = 3'd3;
    localparam logic [2:0] RD_HOLD  = 3'd4;
`ifdef RAM16_CTRL_AUTOCLR_EN
    localparam logic [2:0] CLEAR    = 3'd5;
`endif

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [2:0]            frame_end_state;

    // Where a finished frame goes: straight into the next fill, or back to idle
    assign frame_end_state = ENABLE ? FILL : IDLE;
    assign BUSY            = (state != IDLE);
    assign S_READY         = (state == FILL);

`ifdef RAM16_CTRL_AUTOCLR_EN
    assign RAM_CLR = (state == CLEAR);
`else
    assign RAM_CLR = 1'b0;
`endif

    // RAM strobes decoded from state and ptr; writes only on an input handshake
    always_comb begin
        RAM_EN = 1'b0;
        RAM_WE = 1'b0;
        RAM_A  = '0;
        RAM_DI = 16'h0000;
        case (state)
            FILL: begin
                if (S_VALID) begin
                    RAM_EN = 1'b1;
                    RAM_WE = 1'b1;
                    RAM_A  = ptr;
                    RAM_DI = S_DATA;
                end
            end
            RD_ISSUE: begin
                RAM_EN = 1'b1;
                RAM_A  = ptr;
            end
            default: begin
                RAM_EN = 1'b0;
            end
        endcase
    end

    // Frame sequencer: fill all addresses, then read/present/handshake each word in turn
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            M_VALID   <= 1'b0;
            M_LAST    <= 1'b0;
            M_DATA    <= 16'h0000;
            FRAME_CNT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        state <= FILL;
                        ptr   <= '0;
                    end
                end
                FILL: begin
                    if (S_VALID) begin
                        if (ptr == PTR_LAST) begin
                            ptr   <= '0;
                            state <= RD_ISSUE;
                        end else begin
                            ptr <= ptr + ADDR_WIDTH'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    M_DATA  <= RAM_DO;
                    M_VALID <= 1'b1;
                    M_LAST  <= (ptr == PTR_LAST);
                    state   <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (M_READY) begin
                        M_VALID <= 1'b0;
                        M_LAST  <= 1'b0;
                        if (ptr != PTR_LAST) begin
                            ptr   <= ptr + ADDR_WIDTH'(1);
                            state <= RD_ISSUE;
                        end else begin
                            ptr       <= '0;
                            FRAME_CNT <= FRAME_CNT + FCNT_WIDTH'(1);
`ifdef RAM16_CTRL_AUTOCLR_EN
                            state     <= CLEAR;
`else
                            state     <= frame_end_state;
`endif
                        end
                    end
                end
`ifdef RAM16_CTRL_AUTOCLR_EN
                CLEAR: begin
                    state <= frame_end_state;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram16_frame_ctrl.sv
// tb/tb_ram16_frame_ctrl.sv - scoreboard bench for ram16_frame_ctrl with a RAM16 behavioural model
`timescale 1ns/1ps
module tb_ram16_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic [15:0] S_DATA = 16'h0000;
    logic        M_VALID;
    logic        M_READY = 1'b0;
    logic [15:0] M_DATA;
    logic        M_LAST;
    logic        RAM_EN;
    logic        RAM_WE;
    logic        RAM_CLR;
    logic [1:0]  RAM_A;
    logic [15:0] RAM_DI;
    logic [15:0] RAM_DO;
    logic        BUSY;
    logic [7:0]  FRAME_CNT;

    ram16_frame_ctrl #(.ADDR_WIDTH(2), .FCNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_CLR(RAM_CLR), .RAM_A(RAM_A),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    // RAM16 model: synchronous write, read data valid the cycle after a read strobe
    logic [15:0] mem [4];
    logic [15:0] ram_do_q = 16'h0000;
    assign RAM_DO = ram_do_q;
    initial for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    always @(posedge CLK) begin
        if (RAM_CLR) begin
            for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
        end else if (RAM_EN && RAM_WE) begin
            mem[RAM_A] <= RAM_DI;
        end
        if (RAM_EN && !RAM_WE) ram_do_q <= mem[RAM_A];
    end

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] d; logic last; } exp_t;
    exp_t expq[$];
    int   wr_cnt = 0;
    int   out_cnt = 0;
    int   exp_frames = 0;
    bit   last_prev = 0;
    bit   prev_stall = 0;
    logic [15:0] prev_data = 16'h0000;
    int   m_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready pattern: always ready, random, or stalled
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            case (m_mode)
                0:       M_READY = 1'b1;
                1:       M_READY = 1'($urandom_range(0, 1));
                default: M_READY = 1'b0;
            endcase
        end
    end

    // Monitor: records accepted samples as expected output, checks every presented word
    always @(negedge CLK) begin
        bit   last_now;
        bit   exp_clr;
        exp_t e;
        if (RST) begin
            expq.delete();
            wr_cnt     = 0;
            exp_frames = 0;
            last_prev  = 0;
            prev_stall = 0;
        end else begin
            last_now = 0;
`ifdef RAM16_CTRL_AUTOCLR_EN
            exp_clr = last_prev;
`else
            exp_clr = 0;
`endif
            chk("frame_cnt", 32'(FRAME_CNT), 32'(exp_frames % 256));
            chk("ram_clr", 32'(RAM_CLR), 32'(exp_clr));
            chk("write_only_on_handshake", 32'(RAM_EN && RAM_WE), 32'(S_VALID && S_READY));
            chk("s_ready_m_valid_exclusive", 32'(S_READY && M_VALID), 32'd0);
            if (M_VALID) chk("no_ram_en_while_presenting", 32'(RAM_EN), 32'd0);
            if (prev_stall) begin
                chk("stall_valid_held", 32'(M_VALID), 32'd1);
                chk("stall_data_stable", 32'(M_DATA), 32'(prev_data));
            end
            if (S_VALID && S_READY) begin
                chk("write_addr", 32'(RAM_A), 32'(wr_cnt % 4));
                chk("write_data", 32'(RAM_DI), 32'(S_DATA));
                e.d    = S_DATA;
                e.last = (wr_cnt % 4 == 3);
                expq.push_back(e);
                wr_cnt++;
            end
            if (M_VALID && M_READY) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got data 0x%0h with no sample pending at %0t", M_DATA, $time);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(M_DATA), 32'(e.d));
                    chk("out_last", 32'(M_LAST), 32'(e.last));
                    out_cnt++;
                    if (e.last) begin
                        exp_frames++;
                        last_now = 1;
                    end
                end
            end
            last_prev  = last_now;
            prev_stall = M_VALID && !M_READY;
            prev_data  = M_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        int n;
        S_VALID = 1'b1;
        S_DATA  = d;
        n = 0;
        while (!S_READY && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got S_READY=0 for 300 cycles expected 1");
        end
        tick();
        S_VALID = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", expq.size());
        end
    endtask

    initial begin
        int n;
        // Reset held two cycles
        RST = 1'b1;
        ENABLE = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_s_ready", 32'(S_READY), 0);
        chk("rst_m_valid", 32'(M_VALID), 0);
        chk("rst_m_last", 32'(M_LAST), 0);
        chk("rst_m_data", 32'(M_DATA), 0);
        chk("rst_frame_cnt", 32'(FRAME_CNT), 0);
        chk("rst_ram_en", 32'(RAM_EN), 0);
        chk("rst_ram_we", 32'(RAM_WE), 0);
        chk("rst_ram_clr", 32'(RAM_CLR), 0);
        RST = 1'b0;
        ENABLE = 1'b1;
        tick();
        chk("enable_busy", 32'(BUSY), 1);
        chk("enable_s_ready", 32'(S_READY), 1);

        // Directed frame, consumer always ready
        m_mode = 0;
        send_word(16'h0011);
        send_word(16'h0022);
        send_word(16'h0033);
        send_word(16'h0044);
        chk("s_ready_after_fill", 32'(S_READY), 0);
        wait_drained();
        chk("frame_cnt_1", 32'(FRAME_CNT), 1);

        // Stall the consumer while word 2 is presented
        send_word(16'h0011);
        send_word(16'h0022);
        send_word(16'h0033);
        send_word(16'h0044);
        n = 0;
        while (out_cnt < 6 && n < 100) begin
            tick();
            n++;
        end
        chk("reach_word2", 32'(out_cnt), 6);
        m_mode = 2;
        repeat (13) tick();
        chk("stalled_valid", 32'(M_VALID), 1);
        chk("stalled_data", 32'(M_DATA), 32'h0033);
        m_mode = 0;
        wait_drained();
        chk("frame_cnt_2", 32'(FRAME_CNT), 2);

        // Gapped input, random consumer
        m_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send_word(16'($urandom));
            tick();
        end
        wait_drained();
        chk("frame_cnt_3", 32'(FRAME_CNT), 3);

        // ENABLE dropped mid-frame: frame completes, then idle
        send_word(16'($urandom));
        send_word(16'($urandom));
        ENABLE = 1'b0;
        send_word(16'($urandom));
        send_word(16'($urandom));
        wait_drained();
        repeat (3) tick();
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_s_ready", 32'(S_READY), 0);
        chk("frame_cnt_4", 32'(FRAME_CNT), 4);

        // Reset after two writes aborts the frame
        ENABLE = 1'b1;
        send_word(16'($urandom));
        send_word(16'($urandom));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_frame_cnt", 32'(FRAME_CNT), 0);
        for (int i = 0; i < 4; i++) send_word(16'($urandom));
        wait_drained();
        chk("frame_cnt_after_abort", 32'(FRAME_CNT), 1);

        // Random frames with random gaps and back-pressure
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < 4; i++) begin
                send_word(16'($urandom));
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_drained();
        end
        chk("frame_cnt_final", 32'(FRAME_CNT), 16);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000ns");
        $fatal(1);
    end

endmodule
